router_in_port: RTL and testbench
=================================

Name: router_in_port

Overview:
- Per-port serial packet receiver for the 16x16 crosspoint router; one instance per input port, fed by din[i]/frame_n[i]/valid_n[i].
- Decodes the 4-bit destination address, strips padding, deserializes payload bits LSB-first into bytes, and buffers them in a small FIFO.
- Raises a crossbar request and, once granted, streams bytes to the switch fabric. Protocol errors are flagged.

Parameters:
- FIFO_DEPTH, 4, byte FIFO entries (power of 2, minimum 2).
- ADDR_W, 4, destination address width (bits on the serial line).

Ports:
- clock  in  1  system clock; all sampling on posedge.
- reset_n  in  1  synchronous, active-low reset.
- din  in  1  serial data for this port.
- frame_n  in  1  packet frame, active low; goes high on the final payload bit.
- valid_n  in  1  payload bit qualifier, active low.
- req_addr  out  ADDR_W  destination port requested.
- req_valid  out  1  crossbar request.
- grant  in  1  crossbar grant for this port.
- byte_data  out  8  FIFO head byte.
- byte_last  out  1  head byte is the final byte of the packet.
- byte_valid  out  1  head valid, only while grant=1.
- byte_ready  in  1  fabric accepts the head byte.
- port_busy  out  1  packet in progress or FIFO not empty.
- overflow_err  out  1  one-cycle pulse: byte dropped because the FIFO was full.
- frag_err  out  1  one-cycle pulse: packet ended off a byte boundary, or ended with no payload.
- proto_err  out  1  one-cycle pulse: frame_n low while the port is draining.

Behaviour:
- Synchronous, active-low reset (reset_n sampled on posedge clock) clears everything.
  - All outputs go to 0; FIFO is emptied; state goes to IDLE.
  - The armed flag is cleared. IDLE accepts a new frame only after frame_n has been sampled high at least once (prevents joining a packet mid-stream after reset).
- State IDLE:
  - If armed and frame_n=0: capture din as addr[0], bit_cnt=1, go to ADDR.
- State ADDR:
  - Each cycle capture din into addr[bit_cnt], regardless of valid_n.
  - After addr[ADDR_W-1]: go to PAD; req_addr=addr and req_valid=1 from the next cycle.
  - frame_n high in ADDR: frag_err, return to IDLE, no request.
- State PAD:
  - Cycles with valid_n=1 are ignored; the pad count is not checked.
  - First cycle with valid_n=0: that sample is payload bit 0; go to PAYLOAD.
  - frame_n=1 in PAD before any payload bit: frag_err, go to DRAIN (empty packet).
- State PAYLOAD:
  - Cycle with valid_n=0: shift din into shreg[bit_cnt], bit_cnt++.
  - valid_n=1 cycles are bubbles: no shift, no error.
  - On the 8th bit: push {last=frame_n, byte} into the FIFO, bit_cnt=0.
  - Valid bit with frame_n=1 that is not the 8th bit: push the partial byte zero-extended with last=1, pulse frag_err.
  - Any push with last=1: go to DRAIN.
- State DRAIN:
  - Wait for the FIFO to empty, then deassert req_valid and go to IDLE. IDLE needs frame_n seen high, which it already is.
  - Every cycle with frame_n=0 in DRAIN: pulse proto_err; input ignored.
- FIFO:
  - Push occurs on the clock edge where the byte completes. byte_valid can rise the next cycle, so latency from last bit sampled to byte_valid is 1 cycle if grant=1.
  - Pop when byte_valid && byte_ready.
  - Push while full with no pop: byte dropped, overflow_err pulses. If the dropped byte was last, still go to DRAIN.
  - Push and pop in the same cycle while full: push accepted, no error.
  - Count, pointers and last flags wrap modulo FIFO_DEPTH.
- Grant:
  - grant may deassert mid-packet: byte_valid drops combinationally and the FIFO holds.
  - grant is ignored while req_valid=0.
- port_busy = (state != IDLE) || FIFO not empty.
- Reset mid-packet aborts all state and clears the FIFO. A subsequent frame is accepted only after frame_n is sampled high.

Test Plan:
- Address 0xA (din 0,1,0,1), 5 pad cycles, payload 0x3C then 0xA5 (LSB first, frame_n high on the last bit), grant=1, byte_ready=1 -> req_addr=0xA and req_valid from the cycle after addr[3]. Bytes 0x3C (last=0) then 0xA5 (last=1), each byte_valid 1 cycle after its 8th bit. req_valid drops after the last pop; port_busy falls.
- Same packet with valid_n bubbles inserted between payload bits and 0 pad cycles -> identical bytes; no errors.
- grant=0 throughout, payload 6 bytes 0x01..0x06, FIFO_DEPTH=4 -> bytes 0x01..0x04 held; overflow_err pulses twice. DRAIN never exits until grant=1; then 0x01..0x04 pop; last byte 0x04 has last=0.
- Address 0x3, then 11 payload bits with frame_n high on bit 11 -> byte 0xXX then partial byte zero-extended with last=1; frag_err pulses once.
- reset_n=0 for 1 cycle mid-PAYLOAD with frame_n held low -> outputs 0, FIFO empty. No new request until frame_n goes high and then low again.
- frame_n low for 3 cycles during DRAIN -> proto_err pulses 3 times; no new request; FIFO contents unaffected.

Source files
------------

// File: rtl/router_in_port.sv
// Per-port serial packet receiver: address decode, byte deserializer,
// small byte FIFO and crossbar request/stream handshake.
module router_in_port #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              din,
    input  logic              frame_n,
    input  logic              valid_n,
    output logic [ADDR_W-1:0] req_addr,
    output logic              req_valid,
    input  logic              grant,
    output logic [7:0]        byte_data,
    output logic              byte_last,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              port_busy,
    output logic              overflow_err,
    output logic              frag_err,
    output logic              proto_err
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = (ADDR_W > 8) ? $clog2(ADDR_W) : 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_PAD,
        S_PAYLOAD,
        S_DRAIN
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_armed;
    logic [ADDR_W-1:0] r_addr;
    logic [CW-1:0]     r_cnt;
    logic [7:0]        r_shreg;
    logic              r_req;
    logic              r_frag;
    logic              r_ovf;
    logic              r_proto;
    logic [8:0]        r_mem [FIFO_DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [PW:0]       r_count;

    logic [ADDR_W-1:0] w_addr_nxt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [7:0]        w_sh_nxt;
    logic [7:0]        w_byte;
    logic              w_req_nxt;
    logic              w_bit;
    logic              w_push;
    logic [8:0]        w_push_data;
    logic              w_frag;
    logic              w_proto;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_wr;
    logic              w_ovf;
    logic [8:0]        w_head;

    assign w_full  = (r_count == (PW+1)'(FIFO_DEPTH));
    assign w_empty = (r_count == '0);
    assign w_head  = r_mem[r_rptr];
    assign w_pop   = byte_valid && byte_ready;
    assign w_wr    = w_push && (!w_full || w_pop);
    assign w_ovf   = w_push && w_full && !w_pop;
    // Upper shreg bits are zero at byte start, so partial bytes zero-extend.
    assign w_byte  = r_shreg | (8'(din) << r_cnt[2:0]);

    always_comb begin
        w_next      = r_state;
        w_addr_nxt  = r_addr;
        w_cnt_nxt   = r_cnt;
        w_sh_nxt    = r_shreg;
        w_req_nxt   = r_req;
        w_bit       = 1'b0;
        w_push      = 1'b0;
        w_push_data = '0;
        w_frag      = 1'b0;
        w_proto     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_armed && !frame_n) begin
                    w_addr_nxt = ADDR_W'(din);
                    w_cnt_nxt  = CW'(1);
                    w_next     = S_ADDR;
                end
            end
            S_ADDR: begin
                if (frame_n) begin
                    w_frag = 1'b1;
                    w_next = S_IDLE;
                end else begin
                    w_addr_nxt = r_addr | (ADDR_W'(din) << r_cnt);
                    if (r_cnt == CW'(ADDR_W - 1)) begin
                        w_next    = S_PAD;
                        w_req_nxt = 1'b1;
                        w_cnt_nxt = '0;
                        w_sh_nxt  = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
            S_PAD: begin
                if (!valid_n) begin
                    w_bit  = 1'b1;
                    w_next = S_PAYLOAD;
                end else if (frame_n) begin
                    w_frag = 1'b1;
                    w_next = S_DRAIN;
                end
            end
            S_PAYLOAD: begin
                w_bit = !valid_n;
            end
            S_DRAIN: begin
                w_proto = !frame_n;
                if (w_empty) begin
                    w_req_nxt = 1'b0;
                    w_next    = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (w_bit) begin
            if (r_cnt[2:0] == 3'd7 || frame_n) begin
                w_push      = 1'b1;
                w_push_data = {frame_n, w_byte};
                w_cnt_nxt   = '0;
                w_sh_nxt    = '0;
                w_frag      = frame_n && (r_cnt[2:0] != 3'd7);
                if (frame_n) begin
                    w_next = S_DRAIN;
                end
            end else begin
                w_sh_nxt  = w_byte;
                w_cnt_nxt = r_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_armed <= 1'b0;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_shreg <= '0;
            r_req   <= 1'b0;
            r_frag  <= 1'b0;
            r_ovf   <= 1'b0;
            r_proto <= 1'b0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            r_armed <= r_armed | frame_n;
            r_addr  <= w_addr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shreg <= w_sh_nxt;
            r_req   <= w_req_nxt;
            r_frag  <= w_frag;
            r_ovf   <= w_ovf;
            r_proto <= w_proto;
            if (w_wr) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr) begin
            r_mem[r_wptr] <= w_push_data;
        end
    end

    assign req_addr     = r_addr;
    assign req_valid    = r_req;
    assign byte_valid   = r_req && grant && !w_empty;
    assign byte_data    = w_empty ? 8'd0 : w_head[7:0];
    assign byte_last    = !w_empty && w_head[8];
    assign port_busy    = (r_state != S_IDLE) || !w_empty;
    assign overflow_err = r_ovf;
    assign frag_err     = r_frag;
    assign proto_err    = r_proto;

endmodule

// File: tb/tb_router_in_port.sv
// Directed bench for router_in_port: packet decode, bubbles, overflow,
// fragments, mid-packet reset and drain protocol errors.
module tb_router_in_port;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       din;
    logic       frame_n;
    logic       valid_n;
    logic [3:0] req_addr;
    logic       req_valid;
    logic       grant;
    logic [7:0] byte_data;
    logic       byte_last;
    logic       byte_valid;
    logic       byte_ready;
    logic       port_busy;
    logic       overflow_err;
    logic       frag_err;
    logic       proto_err;

    int n_chk = 0;
    int n_err = 0;
    int n_frag = 0;
    int n_ovf = 0;
    int n_proto = 0;
    logic [8:0] popq [$];

    bit         pend;
    bit         rq_first;
    logic [3:0] rq_addr;
    logic [7:0] pexp;
    logic       pexp_last;
    int         base;
    int         e0;

    router_in_port #(.FIFO_DEPTH(4), .ADDR_W(4)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .din          (din),
        .frame_n      (frame_n),
        .valid_n      (valid_n),
        .req_addr     (req_addr),
        .req_valid    (req_valid),
        .grant        (grant),
        .byte_data    (byte_data),
        .byte_last    (byte_last),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .port_busy    (port_busy),
        .overflow_err (overflow_err),
        .frag_err     (frag_err),
        .proto_err    (proto_err)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (byte_valid && byte_ready) popq.push_back({byte_last, byte_data});
        if (frag_err) n_frag++;
        if (overflow_err) n_ovf++;
        if (proto_err) n_proto++;
    end

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic d, input logic f, input logic v);
        @(posedge clock);
        #1;
        din = d;
        frame_n = f;
        valid_n = v;
    endtask

    task automatic step(input logic d, input logic f, input logic v,
                        input bit lat);
        drive(d, f, v);
        if (rq_first) begin
            if (lat) begin
                chk("req_valid", req_valid, 1);
                chk("req_addr", req_addr, rq_addr);
            end
            rq_first = 0;
        end
        if (pend) begin
            if (lat) begin
                chk("lat_valid", byte_valid, 1);
                chk("lat_data", byte_data, pexp);
                chk("lat_last", byte_last, pexp_last);
            end
            pend = 0;
        end
    endtask

    task automatic send(input logic [3:0] a, input int npad,
                        input logic [63:0] pl, input int nbits,
                        input bit bub, input bit lat);
        for (int i = 0; i < 4; i++) drive(a[i], 1'b0, 1'b1);
        if (lat) chk("req_pre", req_valid, 0);
        rq_first = 1;
        rq_addr = a;
        for (int j = 0; j < npad; j++) step(1'b0, 1'b0, 1'b1, lat);
        for (int i = 0; i < nbits; i++) begin
            if (bub && i > 0) step(1'b0, 1'b0, 1'b1, lat);
            step(pl[i], (i == nbits - 1), 1'b0, lat);
            if ((i % 8) == 7 || i == nbits - 1) begin
                pend = 1;
                pexp = 8'(pl >> ((i / 8) * 8));
                pexp_last = (i == nbits - 1);
            end
        end
        step(1'b0, 1'b1, 1'b1, lat);
    endtask

    initial begin
        pend = 0;
        rq_first = 0;
        reset_n = 0;
        din = 0;
        frame_n = 1;
        valid_n = 1;
        grant = 0;
        byte_ready = 1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_req", req_valid, 0);
        chk("rst_addr", req_addr, 0);
        chk("rst_bv", byte_valid, 0);
        chk("rst_bd", byte_data, 0);
        chk("rst_busy", port_busy, 0);
        chk("rst_errs", {overflow_err, frag_err, proto_err}, 0);
        reset_n = 1;
        repeat (2) drive(1'b0, 1'b1, 1'b1);

        // basic packet with padding
        grant = 1;
        base = popq.size();
        e0 = n_frag + n_ovf + n_proto;
        send(4'hA, 5, 64'hA53C, 16, 0, 1);
        repeat (4) drive(1'b0, 1'b1, 1'b1);
        chk("t1_npop", popq.size() - base, 2);
        chk("t1_b0", popq[base], 9'h03C);
        chk("t1_b1", popq[base+1], 9'h1A5);
        chk("t1_req", req_valid, 0);
        chk("t1_busy", port_busy, 0);
        chk("t1_err", n_frag + n_ovf + n_proto - e0, 0);

        // bubbles, no pad
        base = popq.size();
        e0 = n_frag + n_ovf + n_proto;
        send(4'hA, 0, 64'hA53C, 16, 1, 1);
        repeat (4) drive(1'b0, 1'b1, 1'b1);
        chk("t2_npop", popq.size() - base, 2);
        chk("t2_b0", popq[base], 9'h03C);
        chk("t2_b1", popq[base+1], 9'h1A5);
        chk("t2_err", n_frag + n_ovf + n_proto - e0, 0);
        chk("t2_busy", port_busy, 0);

        // overflow with grant held off, then drain protocol errors
        grant = 0;
        base = popq.size();
        e0 = n_ovf;
        send(4'h5, 2, 64'h060504030201, 48, 0, 0);
        repeat (3) drive(1'b0, 1'b1, 1'b1);
        chk("t3_ovf", n_ovf - e0, 2);
        chk("t3_req", req_valid, 1);
        chk("t3_addr", req_addr, 4'h5);
        chk("t3_bv", byte_valid, 0);
        chk("t3_busy", port_busy, 1);
        e0 = n_proto;
        repeat (3) drive(1'b0, 1'b0, 1'b1);
        repeat (2) drive(1'b0, 1'b1, 1'b1);
        chk("t6_proto", n_proto - e0, 3);
        chk("t6_req", req_valid, 1);
        chk("t6_nopop", popq.size() - base, 0);
        grant = 1;
        repeat (8) drive(1'b0, 1'b1, 1'b1);
        chk("t3_npop", popq.size() - base, 4);
        for (int k = 0; k < 4; k++) begin
            chk("t3_byte", popq[base+k], 9'(k + 1));
        end
        chk("t3_req_end", req_valid, 0);
        chk("t3_busy_end", port_busy, 0);

        // fragment: one byte plus 3 bits
        base = popq.size();
        e0 = n_frag;
        send(4'h3, 1, 64'h055A, 11, 0, 1);
        repeat (4) drive(1'b0, 1'b1, 1'b1);
        chk("t4_frag", n_frag - e0, 1);
        chk("t4_npop", popq.size() - base, 2);
        chk("t4_b0", popq[base], 9'h05A);
        chk("t4_b1", popq[base+1], 9'h105);
        chk("t4_busy", port_busy, 0);

        // reset mid-payload with frame_n held low
        base = popq.size();
        for (int i = 0; i < 4; i++) drive(i[0], 1'b0, 1'b1);
        repeat (5) drive(1'b1, 1'b0, 1'b0);
        chk("t5_busy_pre", port_busy, 1);
        @(posedge clock);
        #1;
        reset_n = 0;
        @(posedge clock);
        #1;
        reset_n = 1;
        chk("t5_req", req_valid, 0);
        chk("t5_addr", req_addr, 0);
        chk("t5_bv", byte_valid, 0);
        chk("t5_busy", port_busy, 0);
        repeat (6) drive(1'b1, 1'b0, 1'b0);
        chk("t5_req_hold", req_valid, 0);
        chk("t5_busy_hold", port_busy, 0);
        drive(1'b0, 1'b1, 1'b1);
        send(4'hC, 1, 64'h77, 8, 0, 1);
        repeat (4) drive(1'b0, 1'b1, 1'b1);
        chk("t5_npop", popq.size() - base, 1);
        chk("t5_b0", popq[base], 9'h177);
        chk("t5_busy_end", port_busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
